mixcolumns_iter: RTL and testbench

- AES-128 MixColumns round stage that sits directly downstream of shiftrow.
- It consumes the 128-bit ShiftRows state and emits the mixed state to the AddRoundKey stage.
- It is iterative: it processes COLS_PER_CYCLE 32-bit columns per clock, with a valid/ready handshake on both sides.
- It has a Bypass input for the final AES round, which omits MixColumns.

---
 rtl/mixcolumns_iter_pkg.sv | 22 ++
 rtl/mixcolumns_iter_col.sv | 21 ++
 rtl/mixcolumns_iter.sv | 125 ++++++++++++
 tb/tb_mixcolumns_iter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mixcolumns_iter_pkg.sv
// Shared AES definitions for the round datapath: FSM encodings, the GF(2^8)
// reduction constant and the xtime/3x helpers reused by other AES stages.
package mixcolumns_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] AES_POLY = 8'h1b;
  localparam int         NUM_COLS = 4;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

endpackage

// File: rtl/mixcolumns_iter_col.sv
// Combinational MixColumns of one 32-bit column; byte 0 sits in the MSB byte.
module mixcolumn_col
  import mixcolumns_iter_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] b
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = a[31:24];
  assign a1 = a[23:16];
  assign a2 = a[15:8];
  assign a3 = a[7:0];

  assign b[31:24] = xtime(a0) ^ mul3(a1) ^ a2 ^ a3;
  assign b[23:16] = a0 ^ xtime(a1) ^ mul3(a2) ^ a3;
  assign b[15:8]  = a0 ^ a1 ^ xtime(a2) ^ mul3(a3);
  assign b[7:0]   = mul3(a0) ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/mixcolumns_iter.sv
// Iterative AES MixColumns stage: mixes COLS_PER_CYCLE columns per clock between
// valid/ready handshakes, with a bypass path for the final round.
module mixcolumns_iter
  import mixcolumns_iter_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [127:0] Data_in,
  input  logic         In_valid,
  output logic         In_ready,
  input  logic         Bypass,
  output logic [127:0] Data_out,
  output logic         Out_valid,
  input  logic         Out_ready
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // With 4 columns per cycle the step wraps to 0, so col simply stays at 0.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - COLS_PER_CYCLE);

  state_t       state, state_d;
  logic [1:0]   col, col_d;
  logic [127:0] work, work_d, work_mix, data_out_d;
  logic         accept;

  logic [31:0]  cols    [NUM_COLS];
  logic [31:0]  mix_in  [COLS_PER_CYCLE];
  logic [31:0]  mix_out [COLS_PER_CYCLE];
  logic [1:0]   sel     [COLS_PER_CYCLE];

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_split
    assign cols[i] = work[127-32*i -: 32];
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_mix
    assign sel[k]    = col + 2'(k);
    assign mix_in[k] = cols[sel[k]];
    mixcolumn_col u_col (
      .a (mix_in[k]),
      .b (mix_out[k])
    );
  end

  always_comb begin
    work_mix = work;
    for (int i = 0; i < NUM_COLS; i++) begin
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
        if (sel[k] == 2'(i)) work_mix[127-32*i -: 32] = mix_out[k];
      end
    end
  end

  always_comb begin
    In_ready   = 1'b0;
    Out_valid  = 1'b0;
    state_d    = state;
    col_d      = col;
    work_d     = work;
    data_out_d = Data_out;

    case (state)
      IDLE: In_ready = 1'b1;
      DONE: begin
        Out_valid = 1'b1;
        In_ready  = Out_ready;
        if (Out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    accept = In_valid && In_ready;

    case (state)
      IDLE, DONE: begin
        // A new accept overrides the drop to IDLE, giving bubble-free back-to-back.
        if (accept) begin
          if (Bypass) begin
            data_out_d = Data_in;
            state_d    = DONE;
          end else begin
            work_d  = Data_in;
            col_d   = 2'd0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        work_d = work_mix;
        if (col == LAST_COL) begin
          data_out_d = work_mix;
          col_d      = 2'd0;
          state_d    = DONE;
        end else begin
          col_d = col + COL_STEP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      col      <= 2'd0;
      Data_out <= 128'h0;
    end else begin
      state    <= state_d;
      col      <= col_d;
      Data_out <= data_out_d;
    end
  end

  always_ff @(posedge CLK) begin
    work <= work_d;
  end

endmodule

// File: tb/tb_mixcolumns_iter.sv
// Scoreboard bench: one lane per COLS_PER_CYCLE value (1, 2, 4), each with its
// own driver, expected-result queue and output monitor.
module tb_mixcolumns_iter;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN    = 128'hd4d4d4d5_2d26314c_00000000_01010101;
  localparam logic [127:0] V2_OUT   = 128'hd5d5d7d6_4d7ebdf8_00000000_01010101;
  localparam logic [127:0] BYP_IN   = 128'h11000000_00000000_00000000_00000001;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int lane, input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s: got %h, expected %h", lane, name, act, exp);
    end
  endtask

  // Polynomial product over GF(2), then long division by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'(9'h11b) << (i - 8);
    return p[7:0];
  endfunction

  // Circulant matrix with first row (2,3,1,1) applied to each column.
  function automatic logic [127:0] mix_ref(input logic [127:0] s);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] r;
    coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gf_mul(coef[(j - row + 4) % 4], s[127 - 32*c - 8*j -: 8]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int C   = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    localparam int LAT = 4 / C;
    localparam int RST_AFTER = (C == 1) ? 2 : ((C == 2) ? 1 : 0);

    logic         rst, in_valid, in_ready, bypass, out_valid, out_ready;
    logic [127:0] data_in, data_out;
    logic [127:0] expq[$];
    logic         done = 1'b0;

    mixcolumns_iter #(.COLS_PER_CYCLE(C)) dut (
      .CLK       (clk),
      .RST       (rst),
      .Data_in   (data_in),
      .In_valid  (in_valid),
      .In_ready  (in_ready),
      .Bypass    (bypass),
      .Data_out  (data_out),
      .Out_valid (out_valid),
      .Out_ready (out_ready)
    );

    always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL lane%0d unexpected_output: got %h, expected no output", g, data_out);
        end else begin
          chk(g, "data_out", data_out, expq.pop_front());
        end
      end
    end

    task automatic idle_cycle(input bit rnd);
      if (rnd) out_ready = 1'($urandom);
      data_in = {$urandom, $urandom, $urandom, $urandom};
      bypass  = 1'($urandom);
      @(posedge clk); #1;
    endtask

    task automatic send(input logic [127:0] d, input bit byp, input logic [127:0] exp,
                        input bit push, input bit rnd, output int waits);
      logic acc;
      data_in  = d;
      bypass   = byp;
      in_valid = 1'b1;
      waits    = 0;
      forever begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        if (acc) break;
        waits++;
        if (waits > 200) begin
          chk(g, "accept_timeout", 128'(waits), 128'd0);
          break;
        end
        if (rnd) out_ready = 1'($urandom);
      end
      in_valid = 1'b0;
      if (push && acc) expq.push_back(exp);
    endtask

    task automatic check_latency(input string name, input int exp_lat);
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      chk(g, name, 128'(n), 128'(exp_lat));
    endtask

    initial begin
      int           w, n;
      logic [127:0] d, saved;
      bit           byp;
      rst = 1'b1; in_valid = 1'b0; bypass = 1'b0; data_in = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk(g, "reset_out_valid", 128'(out_valid), 128'd0);
      chk(g, "reset_data_out", data_out, 128'h0);
      chk(g, "reset_in_ready", 128'(in_ready), 128'd1);
      rst = 1'b0;
      idle_cycle(1'b0);

      send(FIPS_IN, 1'b0, FIPS_OUT, 1'b1, 1'b0, w);
      check_latency("fips_latency", LAT);
      idle_cycle(1'b0);
      send(V2_IN, 1'b0, V2_OUT, 1'b1, 1'b0, w);
      check_latency("v2_latency", LAT);
      idle_cycle(1'b0);
      send(BYP_IN, 1'b1, BYP_IN, 1'b1, 1'b0, w);
      check_latency("bypass_latency", 0);
      idle_cycle(1'b0);

      // Backpressure in DONE, then release together with a new accept.
      out_ready = 1'b0;
      send(V2_IN, 1'b0, V2_OUT, 1'b1, 1'b0, w);
      check_latency("bp_latency", LAT);
      saved = data_out;
      repeat (6) begin
        @(posedge clk); #1;
        chk(g, "hold_data", data_out, saved);
        chk(g, "hold_flags", 128'({out_valid, in_ready}), 128'(2'b10));
      end
      out_ready = 1'b1;
      send(FIPS_IN, 1'b0, FIPS_OUT, 1'b1, 1'b0, w);
      chk(g, "b2b_no_wait", 128'(w), 128'd0);
      chk(g, "b2b_busy_no_valid", 128'(out_valid), 128'd0);
      check_latency("b2b_latency", LAT);
      idle_cycle(1'b0);
      idle_cycle(1'b0);

      // Reset in the middle of an operation; its result must never appear.
      send(V2_IN, 1'b0, '0, 1'b0, 1'b0, w);
      repeat (RST_AFTER) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk(g, "midrst_out_valid", 128'(out_valid), 128'd0);
      chk(g, "midrst_data_out", data_out, 128'h0);
      chk(g, "midrst_in_ready", 128'(in_ready), 128'd1);
      idle_cycle(1'b0);
      send(FIPS_IN, 1'b0, FIPS_OUT, 1'b1, 1'b0, w);
      check_latency("post_rst_latency", LAT);
      idle_cycle(1'b0);

      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 2)) idle_cycle(1'b1);
        d   = {$urandom, $urandom, $urandom, $urandom};
        byp = ($urandom_range(0, 3) == 0);
        send(d, byp, byp ? d : mix_ref(d), 1'b1, 1'b1, w);
      end
      out_ready = 1'b1;
      n = 0;
      while (expq.size() != 0 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      chk(g, "drain_queue_empty", 128'(expq.size()), 128'd0);
      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(lane[0].done && lane[1].done && lane[2].done) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (!(lane[0].done && lane[1].done && lane[2].done)) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: got %0d cycles, expected all lanes done", t);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
